// File: rtl/pc_sequencer_if.sv
// ============================================================================
// Module   : pc_sequencer_if
// Brief    : Fetch handshake, decode and PC bus of the program-counter stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface pc_sequencer_if #(
  parameter int PC_WIDTH = 32
);
  logic                imem_ack;
  logic                is_branch;
  logic                branch_taken;
  logic [15:0]         branch_offset;
  logic                is_jump;
  logic [25:0]         jump_index;
  logic                is_jr;
  logic [PC_WIDTH-1:0] jr_target;
  logic                stall;
  logic                imem_req;
  logic [PC_WIDTH-1:0] pc;
  logic [PC_WIDTH-1:0] pc_plus4;
  logic                instr_valid;
  logic                addr_err;

  // Sequencer side
  modport slave (
    input  imem_ack, is_branch, branch_taken, branch_offset,
           is_jump, jump_index, is_jr, jr_target, stall,
    output imem_req, pc, pc_plus4, instr_valid, addr_err
  );

  // Memory / decode / datapath side
  modport master (
    output imem_ack, is_branch, branch_taken, branch_offset,
           is_jump, jump_index, is_jr, jr_target, stall,
    input  imem_req, pc, pc_plus4, instr_valid, addr_err
  );
endinterface

`default_nettype wire

// File: rtl/pc_sequencer.sv
// ============================================================================
// Module   : pc_sequencer
// Brief    : PC register with BOOT/FETCH/EXEC handshake and jr/j/branch/seq
//            next-PC selection. Optional macro PC_ALIGN_CHECK_EN enables the
//            misaligned jr target check.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pc_sequencer #(
  parameter int                  PC_WIDTH     = 32,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = 32'h0000_3000
) (
  input  wire          clk,
  input  wire          rst,
  pc_sequencer_if.slave bus
);

  localparam logic [1:0] S_BOOT  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_EXEC  = 2'd2;

  logic [1:0]          r_state;
  logic [PC_WIDTH-1:0] r_pc;
  logic [PC_WIDTH-1:0] w_pc_plus4;
  logic [PC_WIDTH-1:0] w_branch_disp;
  logic [PC_WIDTH-1:0] w_next_pc;
  logic                w_commit;
  logic                w_hold_pc;

  assign w_pc_plus4    = r_pc + PC_WIDTH'(4);
  assign w_branch_disp = {{(PC_WIDTH-18){bus.branch_offset[15]}}, bus.branch_offset, 2'b00};
  assign w_commit      = (r_state == S_EXEC) && !bus.stall;

  always_comb begin
    w_next_pc = w_pc_plus4;
    if (bus.is_jr) begin
      w_next_pc = bus.jr_target;
    end else if (bus.is_jump) begin
      w_next_pc = {w_pc_plus4[PC_WIDTH-1:28], bus.jump_index, 2'b00};
    end else if (bus.is_branch && bus.branch_taken) begin
      w_next_pc = w_pc_plus4 + w_branch_disp;
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  logic r_addr_err;

  // A misaligned jr keeps the PC so the same instruction is refetched.
  assign w_hold_pc = bus.is_jr && (bus.jr_target[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr_err <= 1'b0;
    end else begin
      r_addr_err <= w_commit && w_hold_pc;
    end
  end

  assign bus.addr_err = r_addr_err;
`else
  assign w_hold_pc    = 1'b0;
  assign bus.addr_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_BOOT;
      r_pc    <= RESET_VECTOR;
    end else begin
      case (r_state)
        S_BOOT: begin
          r_state <= S_FETCH;
        end
        S_FETCH: begin
          if (bus.imem_ack) begin
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (!bus.stall) begin
            r_state <= S_FETCH;
            if (!w_hold_pc) begin
              r_pc <= w_next_pc;
            end
          end
        end
        default: begin
          r_state <= S_BOOT;
        end
      endcase
    end
  end

  assign bus.imem_req    = (r_state == S_FETCH);
  assign bus.instr_valid = (r_state == S_EXEC);
  assign bus.pc          = r_pc;
  assign bus.pc_plus4    = w_pc_plus4;

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// ============================================================================
// Module   : tb_pc_sequencer
// Brief    : Directed and randomized checks of pc_sequencer against an
//            instruction-level reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pc_sequencer;

  localparam logic [31:0] c_reset_vector = 32'h0000_3000;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  pc_sequencer_if #(.PC_WIDTH(32)) bus ();

  pc_sequencer #(
    .PC_WIDTH     (32),
    .RESET_VECTOR (c_reset_vector)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks   = 0;
  int n_errors   = 0;
  int valid_seen = 0;
  int cyc        = 0;

  // Model: 0 = post-reset gap, 1 = waiting for fetch data, 2 = executing
  int          m_phase = 0;
  logic [31:0] m_pc    = c_reset_vector;
  logic        m_err   = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_target(input logic [31:0] cur, input bit br, input bit tk,
                                             input logic [15:0] off, input bit j,
                                             input logic [25:0] idx, input bit jr,
                                             input logic [31:0] tgt);
    logic [31:0]        seq  = cur + 32'd4;
    logic signed [31:0] soff = $signed({{16{off[15]}}, off});
    if (jr) return tgt;
    if (j) return (seq & 32'hF000_0000) | ({6'd0, idx} << 2);
    if (br && tk) return seq + 32'(soff * 4);
    return seq;
  endfunction

  task automatic cycle(input bit r, input bit a, input bit st, input bit br, input bit tk,
                       input logic [15:0] off, input bit j, input logic [25:0] idx,
                       input bit jr, input logic [31:0] tgt);
    @(negedge clk);
    check("imem_req",    32'(bus.imem_req),    32'(m_phase == 1));
    check("instr_valid", 32'(bus.instr_valid), 32'(m_phase == 2));
    check("pc",          bus.pc,               m_pc);
    check("pc_plus4",    bus.pc_plus4,         m_pc + 32'd4);
    check("addr_err",    32'(bus.addr_err),    32'(m_err));
    if (bus.instr_valid) valid_seen++;
    rst               = r;
    bus.imem_ack      = a;
    bus.stall         = st;
    bus.is_branch     = br;
    bus.branch_taken  = tk;
    bus.branch_offset = off;
    bus.is_jump       = j;
    bus.jump_index    = idx;
    bus.is_jr         = jr;
    bus.jr_target     = tgt;
    @(posedge clk);
    cyc++;
    if (r) begin
      m_phase = 0;
      m_pc    = c_reset_vector;
      m_err   = 1'b0;
    end else begin
      m_err = 1'b0;
      if (m_phase == 0) begin
        m_phase = 1;
      end else if (m_phase == 1) begin
        if (a) m_phase = 2;
      end else if (!st) begin
`ifdef PC_ALIGN_CHECK_EN
        if (jr && tgt[1:0] != 2'b00) m_err = 1'b1;
        else m_pc = ref_target(m_pc, br, tk, off, j, idx, jr, tgt);
`else
        m_pc = ref_target(m_pc, br, tk, off, j, idx, jr, tgt);
`endif
        m_phase = 1;
      end
    end
  endtask

  // Cycle with random decode inputs that the design must ignore
  task automatic cycle_junk(input bit r, input bit a, input bit st);
    cycle(r, a, st, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom),
          1'($urandom_range(0, 1)), 26'($urandom), 1'($urandom_range(0, 1)), $urandom);
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 26'd0, 1'b0, 32'd0);
  endtask

  task automatic do_instr(input int delay, input int stalls, input bit br, input bit tk,
                          input logic [15:0] off, input bit j, input logic [25:0] idx,
                          input bit jr, input logic [31:0] tgt);
    int guard = 0;
    while (m_phase != 1 && guard < 4) begin
      idle();
      guard++;
    end
    check("sync_fetch", 32'(m_phase), 32'd1);
    repeat (delay) cycle_junk(1'b0, 1'b0, 1'($urandom_range(0, 1)));
    cycle_junk(1'b0, 1'b1, 1'($urandom_range(0, 1)));
    repeat (stalls) cycle_junk(1'b0, 1'($urandom_range(0, 1)), 1'b1);
    cycle(1'b0, 1'b0, 1'b0, br, tk, off, j, idx, jr, tgt);
    #1;
  endtask

  task automatic seq_instr(input int delay);
    do_instr(delay, 0, 1'b0, 1'b0, 16'd0, 1'b0, 26'd0, 1'b0, 32'd0);
  endtask

  task automatic jr_instr(input logic [31:0] tgt);
    do_instr(0, 0, 1'b0, 1'b0, 16'd0, 1'b0, 26'd0, 1'b1, tgt);
  endtask

  initial begin
    int start;
    rst               = 1'b1;
    bus.imem_ack      = 1'b0;
    bus.stall         = 1'b0;
    bus.is_branch     = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.branch_offset = 16'd0;
    bus.is_jump       = 1'b0;
    bus.jump_index    = 26'd0;
    bus.is_jr         = 1'b0;
    bus.jr_target     = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_pc",  bus.pc,               32'h0000_3000);
    check("rst_req", 32'(bus.imem_req),    32'd0);
    check("rst_val", 32'(bus.instr_valid), 32'd0);
    idle();
    #1;
    check("boot_to_fetch_req", 32'(bus.imem_req), 32'd1);

    start = cyc;
    seq_instr(0);
    check("seq_pc", bus.pc, 32'h0000_3004);
    check("min_period", 32'(cyc - start), 32'd2);

    start = cyc;
    seq_instr(3);
    check("seq_pc_delay3", bus.pc, 32'h0000_3008);
    check("period_delay3", 32'(cyc - start), 32'd5);

    jr_instr(32'h0000_3010);
    do_instr(0, 0, 1'b1, 1'b1, 16'hFFFE, 1'b0, 26'd0, 1'b0, 32'd0);
    check("branch_taken", bus.pc, 32'h0000_300C);
    jr_instr(32'h0000_3010);
    do_instr(0, 0, 1'b1, 1'b0, 16'hFFFE, 1'b0, 26'd0, 1'b0, 32'd0);
    check("branch_not_taken", bus.pc, 32'h0000_3014);
    do_instr(0, 0, 1'b0, 1'b1, 16'h0040, 1'b0, 26'd0, 1'b0, 32'd0);
    check("taken_without_branch", bus.pc, 32'h0000_3018);

    jr_instr(32'h0000_3000);
    do_instr(0, 0, 1'b1, 1'b1, 16'h0010, 1'b1, 26'h0000100, 1'b1, 32'h0000_4000);
    check("jr_over_jump", bus.pc, 32'h0000_4000);
    jr_instr(32'h0000_3000);
    do_instr(0, 0, 1'b1, 1'b1, 16'h0010, 1'b1, 26'h0000100, 1'b0, 32'd0);
    check("jump_only", bus.pc, 32'h0000_0400);

    valid_seen = 0;
    do_instr(0, 3, 1'b0, 1'b0, 16'd0, 1'b0, 26'd0, 1'b0, 32'd0);
    check("stall_valid_cycles", 32'(valid_seen), 32'd4);
    check("stall_pc", bus.pc, 32'h0000_0404);

    cycle_junk(1'b0, 1'b0, 1'b0);
    cycle_junk(1'b1, 1'b1, 1'b0);
    #1;
    check("midfetch_rst_pc",  bus.pc,            32'h0000_3000);
    check("midfetch_rst_req", 32'(bus.imem_req), 32'd0);
    cycle_junk(1'b0, 1'b1, 1'b0);
    #1;
    check("late_ack_req", 32'(bus.imem_req),    32'd1);
    check("late_ack_val", 32'(bus.instr_valid), 32'd0);

    jr_instr(32'hFFFF_FFFC);
    seq_instr(1);
    check("wrap_up", bus.pc, 32'h0000_0000);
    do_instr(0, 0, 1'b1, 1'b1, 16'hFFFE, 1'b0, 26'd0, 1'b0, 32'd0);
    check("wrap_down", bus.pc, 32'hFFFF_FFFC);

    jr_instr(32'h0000_4002);
`ifdef PC_ALIGN_CHECK_EN
    check("misalign_pc_held", bus.pc,            32'hFFFF_FFFC);
    check("misalign_err",     32'(bus.addr_err), 32'd1);
    check("misalign_refetch", 32'(bus.imem_req), 32'd1);
`else
    check("jr_verbatim",      bus.pc,            32'h0000_4002);
    check("no_addr_err",      32'(bus.addr_err), 32'd0);
`endif

    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 99) == 0),
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 2) == 0),
            1'($urandom_range(0, 1)),
            16'($urandom),
            ($urandom_range(0, 4) == 0),
            26'($urandom),
            ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC));
    end
    idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
